// File: rtl/jk_pkg.sv
// Shared definitions for the JK-based counter register: mode codes and
// the per-bit JK action encodings.
package jk_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_JK = 2'b00;
  localparam mode_t MODE_UP = 2'b01;
  localparam mode_t MODE_DN = 2'b10;
  localparam mode_t MODE_LD = 2'b11;

  // Encoded as {j,k} so the input pair casts directly to an action.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_CLEAR  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_act_e;

endpackage

// File: rtl/jk_bit_next.sv
// Combinational next-state function of a single JK flip-flop bit.
module jk_bit_next
  import jk_pkg::*;
(
  input  logic j,
  input  logic k,
  input  logic q,
  output logic q_next
);

  jk_act_e act_s;

  assign act_s = jk_act_e'({j, k});

  // JK characteristic table
  always_comb begin
    q_next = q;
    case (act_s)
      JK_HOLD:   q_next = q;
      JK_CLEAR:  q_next = 1'b0;
      JK_SET:    q_next = 1'b1;
      JK_TOGGLE: q_next = ~q;
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/jk_counter_reg.sv
// WIDTH-bit JK register with up/down modulus counting, parallel load, sync clear/preset.
// Define JK_COUNTER_SAT_EN to make the count modes saturate instead of wrapping.
module jk_counter_reg
  import jk_pkg::*;
#(
  parameter int unsigned      WIDTH      = 4,
  parameter logic [WIDTH-1:0] MAX_COUNT  = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] PRESET_VAL = MAX_COUNT
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             sync_clear,
  input  logic             preset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             wrapped
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic [WIDTH-1:0] jk_nxt_s;
  logic [WIDTH-1:0] ld_val_s;
  logic [WIDTH-1:0] up_s;
  logic [WIDTH-1:0] dn_s;
  logic [WIDTH:0]   q_ext_s;
  logic [WIDTH:0]   max_ext_s;
  logic             at_top_s;
  logic             at_bot_s;
  logic             over_s;
  logic             wrap_s;
  logic             wrapped_r;
  mode_t            mode_s;

  assign mode_s    = mode;
  assign q_ext_s   = {1'b0, q_r};
  assign max_ext_s = {1'b0, MAX_COUNT};
  assign up_s      = q_r + WIDTH'(1'b1);
  assign dn_s      = q_r - WIDTH'(1'b1);

  // Out-of-range states (reachable via JK mode) count as terminal in both directions.
  assign over_s   = (q_ext_s > max_ext_s);
  assign at_top_s = (q_ext_s >= max_ext_s);
  assign at_bot_s = (q_ext_s == {(WIDTH+1){1'b0}}) | over_s;
  assign ld_val_s = (d > MAX_COUNT) ? MAX_COUNT : d;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    jk_bit_next u_bit (
      .j      (j[gi]),
      .k      (k[gi]),
      .q      (q_r[gi]),
      .q_next (jk_nxt_s[gi])
    );
  end

  // Next-state selection in priority order
  always_comb begin
    q_nxt_s = q_r;
    wrap_s  = 1'b0;
    if (sync_clear) begin
      q_nxt_s = {WIDTH{1'b0}};
    end else if (preset) begin
      q_nxt_s = PRESET_VAL;
    end else if (!en) begin
      q_nxt_s = q_r;
    end else begin
      case (mode_s)
        MODE_JK: q_nxt_s = jk_nxt_s;
`ifdef JK_COUNTER_SAT_EN
        MODE_UP: q_nxt_s = at_top_s ? MAX_COUNT : up_s;
        MODE_DN: begin
          if (q_ext_s == {(WIDTH+1){1'b0}}) begin
            q_nxt_s = {WIDTH{1'b0}};
          end else if (over_s) begin
            q_nxt_s = MAX_COUNT;
          end else begin
            q_nxt_s = dn_s;
          end
        end
`else
        MODE_UP: begin
          if (at_top_s) begin
            q_nxt_s = {WIDTH{1'b0}};
            wrap_s  = 1'b1;
          end else begin
            q_nxt_s = up_s;
          end
        end
        MODE_DN: begin
          if (at_bot_s) begin
            q_nxt_s = MAX_COUNT;
            wrap_s  = 1'b1;
          end else begin
            q_nxt_s = dn_s;
          end
        end
`endif
        MODE_LD: q_nxt_s = ld_val_s;
        default: q_nxt_s = q_r;
      endcase
    end
  end

  // State and wrap-pulse registers
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      q_r       <= {WIDTH{1'b0}};
      wrapped_r <= 1'b0;
    end else begin
      q_r       <= q_nxt_s;
      wrapped_r <= wrap_s;
    end
  end

  // clear_n gates tc so it reads low while held in reset.
  assign tc = clear_n & en & ~sync_clear & ~preset &
              (((mode_s == MODE_UP) & at_top_s) | ((mode_s == MODE_DN) & at_bot_s));

  assign q       = q_r;
  assign q_bar   = ~q_r;
  assign wrapped = wrapped_r;

endmodule

// File: tb/tb_jk_counter_reg.sv
// Self-checking bench for jk_counter_reg (WIDTH=4, MAX_COUNT=9, PRESET_VAL=5):
// directed test-plan cases followed by randomized cycles against a reference model.
module tb_jk_counter_reg;
  import jk_pkg::*;

  localparam logic [3:0] MAXC = 4'd9;
  localparam logic [3:0] PV   = 4'd5;

  logic       clk = 1'b0;
  logic       clear_n, sync_clear, preset, en;
  logic [1:0] mode;
  logic [3:0] j, k, d;
  logic [3:0] q, q_bar;
  logic       tc, wrapped;

  int         checks_r = 0;
  int         errors_r = 0;
  logic [3:0] m_q;
  logic       m_wr;

  always #5 clk = ~clk;

  jk_counter_reg #(.WIDTH(4), .MAX_COUNT(MAXC), .PRESET_VAL(PV)) dut (
    .clk(clk), .clear_n(clear_n), .sync_clear(sync_clear), .preset(preset),
    .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .q(q), .q_bar(q_bar), .tc(tc), .wrapped(wrapped)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_tc();
    int qi = int'(m_q);
    int mx = int'(MAXC);
    return clear_n && en && !sync_clear && !preset &&
           ((mode == MODE_UP && qi >= mx) || (mode == MODE_DN && (qi == 0 || qi > mx)));
  endfunction

  // Reference: arithmetic on integers, JK via the characteristic equation.
  task automatic model_edge();
    int qi = int'(m_q);
    int mx = int'(MAXC);
    int nq = qi;
    logic nw = 1'b0;
    if (sync_clear) nq = 0;
    else if (preset) nq = int'(PV);
    else if (!en) nq = qi;
    else begin
      case (mode)
        2'd0: nq = int'((j & ~m_q) | (~k & m_q));
`ifdef JK_COUNTER_SAT_EN
        2'd1: nq = (qi >= mx) ? mx : qi + 1;
        2'd2: nq = (qi == 0) ? 0 : ((qi > mx) ? mx : qi - 1);
`else
        2'd1: if (qi >= mx) begin nq = 0; nw = 1'b1; end else nq = qi + 1;
        2'd2: if (qi == 0 || qi > mx) begin nq = mx; nw = 1'b1; end else nq = qi - 1;
`endif
        default: nq = (int'(d) > mx) ? mx : int'(d);
      endcase
    end
    m_q  = 4'(nq);
    m_wr = nw;
  endtask

  task automatic drive(input logic sc, input logic pr, input logic e, input logic [1:0] md,
                       input logic [3:0] jj, input logic [3:0] kk, input logic [3:0] dd);
    sync_clear = sc; preset = pr; en = e; mode = md; j = jj; k = kk; d = dd;
  endtask

  task automatic step();
    #1;
    check_val("tc", {31'd0, tc}, {31'd0, model_tc()});
    check_val("q_bar", {28'd0, q_bar}, {28'd0, ~m_q});
    @(posedge clk);
    model_edge();
    #1;
    check_val("q", {28'd0, q}, {28'd0, m_q});
    check_val("wrapped", {31'd0, wrapped}, {31'd0, m_wr});
  endtask

  initial begin
    clear_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, MODE_DN, 4'h0, 4'h0, 4'h0);
    m_q = 4'd0; m_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_q", {28'd0, q}, 32'd0);
    check_val("rst_qbar", {28'd0, q_bar}, 32'hF);
    check_val("rst_wrapped", {31'd0, wrapped}, 32'd0);
    check_val("rst_tc", {31'd0, tc}, 32'd0);
    clear_n = 1'b1;

    // Count up across the modulus boundary
    drive(1'b0, 1'b0, 1'b1, MODE_LD, 4'h0, 4'h0, 4'd8); step();
    drive(1'b0, 1'b0, 1'b1, MODE_UP, 4'h0, 4'h0, 4'h0); step();
    check_val("up_to_max", {28'd0, q}, 32'd9);
    #1 check_val("tc_at_max", {31'd0, tc}, 32'd1);
    step();
`ifdef JK_COUNTER_SAT_EN
    step(); step();
    check_val("sat_up_q", {28'd0, q}, 32'd9);
    check_val("sat_up_wr", {31'd0, wrapped}, 32'd0);
    #1 check_val("sat_up_tc", {31'd0, tc}, 32'd1);
`else
    check_val("up_wrap_q", {28'd0, q}, 32'd0);
    check_val("up_wrap_pulse", {31'd0, wrapped}, 32'd1);
    step();
    check_val("up_after_wrap", {28'd0, q}, 32'd1);
    check_val("pulse_one_cycle", {31'd0, wrapped}, 32'd0);
`endif

    // Count down from zero, then from an out-of-range JK value
    drive(1'b1, 1'b0, 1'b1, MODE_UP, 4'h0, 4'h0, 4'h0); step();
    drive(1'b0, 1'b0, 1'b1, MODE_DN, 4'h0, 4'h0, 4'h0); step();
`ifdef JK_COUNTER_SAT_EN
    check_val("sat_dn_q", {28'd0, q}, 32'd0);
`else
    check_val("dn_wrap_q", {28'd0, q}, 32'd9);
    check_val("dn_wrap_pulse", {31'd0, wrapped}, 32'd1);
`endif
    drive(1'b0, 1'b0, 1'b1, MODE_JK, 4'hF, 4'h0, 4'h0); step();
    check_val("jk_set_all", {28'd0, q}, 32'd15);
    drive(1'b0, 1'b0, 1'b1, MODE_DN, 4'h0, 4'h0, 4'h0); step();
    check_val("dn_from_over", {28'd0, q}, 32'd9);

    // JK bitwise and clamped load
    drive(1'b1, 1'b0, 1'b1, MODE_JK, 4'h0, 4'h0, 4'h0); step();
    drive(1'b0, 1'b0, 1'b1, MODE_JK, 4'b1010, 4'b0000, 4'h0); step();
    drive(1'b0, 1'b0, 1'b1, MODE_JK, 4'b0011, 4'b0110, 4'h0); step();
    check_val("jk_mix", {28'd0, q}, 32'b1001);
    drive(1'b0, 1'b0, 1'b1, MODE_LD, 4'h0, 4'h0, 4'hC); step();
    check_val("load_clamp", {28'd0, q}, 32'd9);

    // Priority
    drive(1'b1, 1'b1, 1'b1, MODE_UP, 4'h0, 4'h0, 4'h0);
    #1 check_val("tc_forced_low", {31'd0, tc}, 32'd0);
    step();
    check_val("clr_over_preset", {28'd0, q}, 32'd0);
    drive(1'b0, 1'b1, 1'b1, MODE_UP, 4'h0, 4'h0, 4'h0); step();
    check_val("preset_val", {28'd0, q}, 32'd5);
    drive(1'b0, 1'b0, 1'b0, MODE_UP, 4'h0, 4'h0, 4'h0); step();
    check_val("en_hold", {28'd0, q}, 32'd5);

    // Asynchronous clear mid-count, no clock edge
    drive(1'b0, 1'b0, 1'b1, MODE_LD, 4'h0, 4'h0, 4'd7); step();
    drive(1'b0, 1'b0, 1'b0, MODE_UP, 4'h0, 4'h0, 4'h0);
    #2 clear_n = 1'b0;
    #1 check_val("async_clr_q", {28'd0, q}, 32'd0);
    check_val("async_clr_qbar", {28'd0, q_bar}, 32'hF);
    m_q = 4'd0; m_wr = 1'b0;
    #1 clear_n = 1'b1;
    @(posedge clk); #1;

    // Asynchronous clear cutting a wrapped pulse short
    drive(1'b1, 1'b0, 1'b1, MODE_DN, 4'h0, 4'h0, 4'h0); step();
    drive(1'b0, 1'b0, 1'b1, MODE_DN, 4'h0, 4'h0, 4'h0); step();
    en = 1'b0;
    #2 clear_n = 1'b0;
    #1 check_val("async_cut_wr", {31'd0, wrapped}, 32'd0);
    check_val("async_cut_q", {28'd0, q}, 32'd0);
    m_q = 4'd0; m_wr = 1'b0;
    #1 clear_n = 1'b1;
    @(posedge clk); #1;

    // Randomized operation against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(15) == 0), ($urandom_range(15) == 0), ($urandom_range(7) != 0),
            2'($urandom_range(3)), 4'($urandom), 4'($urandom), 4'($urandom));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
